// File: rtl/gpio_mailbox_pkg.sv
// Shared definitions for the GPIO mailbox: read-side FSM encoding and reset constants.
package gpio_mailbox_pkg;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } rd_state_e;

  localparam logic      RST_TOG   = 1'b0;
  localparam logic      RST_ACK   = 1'b0;
  localparam rd_state_e RST_STATE = R_IDLE;

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous word FIFO with wrap-bit pointers; push on full and pop on empty are dropped.
module mailbox_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // Next pointer and storage state from the filtered push/pop requests.
  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_d     = mem_q;
    if (do_push_s) begin
      mem_d[wptr_q[AW-1:0]] = push_data_i;
      wptr_d                = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer and storage registers; storage cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/gpio_mailbox.sv
// Host/core mailbox over toggle-handshake GPIO bytes, with RX/TX word FIFOs and optional loopback.
module gpio_mailbox
  import gpio_mailbox_pkg::*;
#(
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 8,
  parameter int DEPTH      = 4,
  parameter int LOOPBACK   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BYTE_W-1:0]            h_data_i,
  input  logic                         h_wr_tog_i,
  output logic                         h_wr_ack_o,
  input  logic                         h_rd_tog_i,
  output logic                         h_rd_ack_o,
  output logic [BYTE_W-1:0]            h_data_o,
  output logic                         h_rx_full_o,
  output logic                         h_tx_avail_o,
  output logic [BYTE_W*WORD_BYTES-1:0] dev_rx_data_o,
  output logic                         dev_rx_valid_o,
  input  logic                         dev_rx_ready_i,
  input  logic [BYTE_W*WORD_BYTES-1:0] dev_tx_data_i,
  input  logic                         dev_tx_valid_i,
  output logic                         dev_tx_ready_o
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int CW     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic LB = 1'(LOOPBACK != 0);

  logic wr_sync1_q, wr_sync2_q, rd_sync1_q, rd_sync2_q;
  logic wr_seen_q, wr_seen_d, rd_seen_q, rd_seen_d;
  logic wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic live_q;
  logic [CW-1:0]     wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [WORD_W-1:0] wsr_q, wsr_d, rsr_q, rsr_d;
  logic [BYTE_W-1:0] rdata_q, rdata_d;
  rd_state_e         rstate_q, rstate_d;

  logic              wr_evt_s, wr_last_s, wr_fire_s, rd_evt_s;
  logic [WORD_W-1:0] wr_word_s;
  logic              rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [WORD_W-1:0] rx_head_s;
  logic              tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [WORD_W-1:0] tx_head_s, tx_push_data_s;

  mailbox_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rx_push_s),
    .push_data_i (wr_word_s),
    .pop_i       (rx_pop_s),
    .head_o      (rx_head_s),
    .full_o      (rx_full_s),
    .empty_o     (rx_empty_s)
  );

  mailbox_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (tx_push_s),
    .push_data_i (tx_push_data_s),
    .pop_i       (tx_pop_s),
    .head_o      (tx_head_s),
    .full_o      (tx_full_s),
    .empty_o     (tx_empty_s)
  );

  // Two-flop synchronisers for the asynchronous host toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync1_q <= RST_TOG;
      wr_sync2_q <= RST_TOG;
      rd_sync1_q <= RST_TOG;
      rd_sync2_q <= RST_TOG;
    end else begin
      wr_sync1_q <= h_wr_tog_i;
      wr_sync2_q <= wr_sync1_q;
      rd_sync1_q <= h_rd_tog_i;
      rd_sync2_q <= rd_sync1_q;
    end
  end

  // Write path: shift bytes in LSB first; the final byte waits while RX is full.
  always_comb begin
    wr_evt_s  = (wr_sync2_q != wr_seen_q);
    wr_last_s = (wcnt_q == CNT_LAST);
    wr_fire_s = wr_evt_s && !(wr_last_s && rx_full_s);
    wr_word_s = {h_data_i, wsr_q[WORD_W-1:BYTE_W]};
    wsr_d     = wsr_q;
    wcnt_d    = wcnt_q;
    wr_ack_d  = wr_ack_q;
    wr_seen_d = wr_seen_q;
    rx_push_s = 1'b0;
    if (wr_fire_s) begin
      wsr_d     = wr_word_s;
      wr_ack_d  = ~wr_ack_q;
      wr_seen_d = wr_sync2_q;
      rx_push_s = wr_last_s;
      if (wr_last_s) begin
        wcnt_d = '0;
      end else begin
        wcnt_d = wcnt_q + CNT_ONE;
      end
    end else begin
      wsr_d = wsr_q;
    end
  end

  // Core-side routing: either the core owns both FIFO ends or RX drains straight into TX.
  always_comb begin
    rx_pop_s       = 1'b0;
    tx_push_s      = 1'b0;
    tx_push_data_s = dev_tx_data_i;
    if (LB) begin
      rx_pop_s       = !rx_empty_s && !tx_full_s;
      tx_push_s      = rx_pop_s;
      tx_push_data_s = rx_head_s;
    end else begin
      rx_pop_s       = !rx_empty_s && dev_rx_ready_i;
      tx_push_s      = dev_tx_valid_i && live_q && !tx_full_s;
      tx_push_data_s = dev_tx_data_i;
    end
  end

  // Read FSM: pop a word on the first request, then hand out one byte per request LSB first.
  always_comb begin
    rd_evt_s  = (rd_sync2_q != rd_seen_q);
    rstate_d  = rstate_q;
    rcnt_d    = rcnt_q;
    rsr_d     = rsr_q;
    rdata_d   = rdata_q;
    rd_ack_d  = rd_ack_q;
    rd_seen_d = rd_seen_q;
    tx_pop_s  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (rd_evt_s && !tx_empty_s) begin
          tx_pop_s  = 1'b1;
          rdata_d   = tx_head_s[BYTE_W-1:0];
          rsr_d     = tx_head_s >> BYTE_W;
          rd_ack_d  = ~rd_ack_q;
          rd_seen_d = rd_sync2_q;
          rcnt_d    = CNT_ONE;
          rstate_d  = R_SEND;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_SEND: begin
        if (rd_evt_s) begin
          rdata_d   = rsr_q[BYTE_W-1:0];
          rsr_d     = rsr_q >> BYTE_W;
          rd_ack_d  = ~rd_ack_q;
          rd_seen_d = rd_sync2_q;
          if (rcnt_q == CNT_LAST) begin
            rcnt_d   = '0;
            rstate_d = R_IDLE;
          end else begin
            rcnt_d   = rcnt_q + CNT_ONE;
            rstate_d = R_SEND;
          end
        end else begin
          rstate_d = R_SEND;
        end
      end
      default: begin
        rcnt_d   = '0;
        rstate_d = R_IDLE;
      end
    endcase
  end

  // Handshake, counter, shift-register and FSM state; live_q keeps tx_ready low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_seen_q <= RST_TOG;
      rd_seen_q <= RST_TOG;
      wr_ack_q  <= RST_ACK;
      rd_ack_q  <= RST_ACK;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      wsr_q     <= '0;
      rsr_q     <= '0;
      rdata_q   <= '0;
      rstate_q  <= RST_STATE;
      live_q    <= 1'b0;
    end else begin
      wr_seen_q <= wr_seen_d;
      rd_seen_q <= rd_seen_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      wsr_q     <= wsr_d;
      rsr_q     <= rsr_d;
      rdata_q   <= rdata_d;
      rstate_q  <= rstate_d;
      live_q    <= 1'b1;
    end
  end

  assign h_wr_ack_o     = wr_ack_q;
  assign h_rd_ack_o     = rd_ack_q;
  assign h_data_o       = rdata_q;
  assign h_rx_full_o    = rx_full_s;
  assign h_tx_avail_o   = !tx_empty_s || (rstate_q == R_SEND);
  assign dev_rx_valid_o = !LB && !rx_empty_s;
  assign dev_rx_data_o  = LB ? '0 : rx_head_s;
  assign dev_tx_ready_o = !LB && live_q && !tx_full_s;

endmodule

// File: tb/tb_gpio_mailbox.sv
// Randomised bench for gpio_mailbox: default instance plus a 4-byte loopback instance.
module tb_gpio_mailbox;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  h_data_i = 8'h00;
  logic        h_wr_tog_i = 1'b0, h_rd_tog_i = 1'b0;
  logic        h_wr_ack_o, h_rd_ack_o, h_rx_full_o, h_tx_avail_o;
  logic [7:0]  h_data_o;
  logic [63:0] dev_rx_data_o;
  logic        dev_rx_valid_o, dev_tx_ready_o;
  logic        dev_rx_ready_i = 1'b0, dev_tx_valid_i = 1'b0;
  logic [63:0] dev_tx_data_i = 64'h0;

  logic [7:0]  lb_h_data_i = 8'h00;
  logic        lb_wr_tog = 1'b0, lb_rd_tog = 1'b0;
  logic        lb_wr_ack, lb_rd_ack, lb_rx_full, lb_tx_avail;
  logic [7:0]  lb_h_data_o;
  logic [31:0] lb_rx_data;
  logic        lb_rx_valid, lb_tx_ready;

  int n_vec = 0;
  int n_err = 0;

  gpio_mailbox dut (
    .clk(clk), .rst_n(rst_n),
    .h_data_i(h_data_i), .h_wr_tog_i(h_wr_tog_i), .h_wr_ack_o(h_wr_ack_o),
    .h_rd_tog_i(h_rd_tog_i), .h_rd_ack_o(h_rd_ack_o), .h_data_o(h_data_o),
    .h_rx_full_o(h_rx_full_o), .h_tx_avail_o(h_tx_avail_o),
    .dev_rx_data_o(dev_rx_data_o), .dev_rx_valid_o(dev_rx_valid_o),
    .dev_rx_ready_i(dev_rx_ready_i), .dev_tx_data_i(dev_tx_data_i),
    .dev_tx_valid_i(dev_tx_valid_i), .dev_tx_ready_o(dev_tx_ready_o)
  );

  gpio_mailbox #(.BYTE_W(8), .WORD_BYTES(4), .DEPTH(4), .LOOPBACK(1)) lb (
    .clk(clk), .rst_n(rst_n),
    .h_data_i(lb_h_data_i), .h_wr_tog_i(lb_wr_tog), .h_wr_ack_o(lb_wr_ack),
    .h_rd_tog_i(lb_rd_tog), .h_rd_ack_o(lb_rd_ack), .h_data_o(lb_h_data_o),
    .h_rx_full_o(lb_rx_full), .h_tx_avail_o(lb_tx_avail),
    .dev_rx_data_o(lb_rx_data), .dev_rx_valid_o(lb_rx_valid),
    .dev_rx_ready_i(1'b0), .dev_tx_data_i(32'h0),
    .dev_tx_valid_i(1'b0), .dev_tx_ready_o(lb_tx_ready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Byte i of a word, LSB first.
  function automatic logic [7:0] byte_of(input logic [63:0] w, input int i);
    logic [63:0] t;
    t = w >> (8 * i);
    return t[7:0];
  endfunction

  function automatic logic [63:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  // All host/core tasks start and end #1 after a rising edge.
  task automatic wait_wr_ack(input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc && lat < 0; i++) begin
      @(posedge clk); #1;
      if (h_wr_ack_o == h_wr_tog_i) lat = i;
    end
  endtask

  task automatic wait_rd_ack(input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc && lat < 0; i++) begin
      @(posedge clk); #1;
      if (h_rd_ack_o == h_rd_tog_i) lat = i;
    end
  endtask

  task automatic host_write(input logic [7:0] b, input int maxc, output int lat);
    h_data_i   = b;
    h_wr_tog_i = ~h_wr_tog_i;
    wait_wr_ack(maxc, lat);
  endtask

  task automatic host_read(input int maxc, output int lat, output logic [7:0] b);
    h_rd_tog_i = ~h_rd_tog_i;
    wait_rd_ack(maxc, lat);
    b = h_data_o;
  endtask

  // Returns how many of the 8 bytes were not acked exactly 3 clk after the toggle.
  task automatic write_word(input logic [63:0] w, output int bad);
    int lat;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      host_write(byte_of(w, i), 10, lat);
      if (lat != 3) bad++;
    end
  endtask

  task automatic read_word(output logic [63:0] w, output int bad);
    int lat;
    logic [7:0] b;
    w = 64'h0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      host_read(10, lat, b);
      if (lat != 3) bad++;
      w = w | (64'(b) << (8 * i));
    end
  endtask

  task automatic core_push(input logic [63:0] w);
    dev_tx_data_i  = w;
    dev_tx_valid_i = 1'b1;
    @(posedge clk); #1;
    dev_tx_valid_i = 1'b0;
  endtask

  task automatic core_pop();
    dev_rx_ready_i = 1'b1;
    @(posedge clk); #1;
    dev_rx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (h_wr_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_wr_ack: got %b want 0", h_wr_ack_o); end
    n_vec++; if (h_rd_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_rd_ack: got %b want 0", h_rd_ack_o); end
    n_vec++; if (h_data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", h_data_o); end
    n_vec++; if ({h_rx_full_o, h_tx_avail_o, dev_rx_valid_o, dev_tx_ready_o} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {h_rx_full_o, h_tx_avail_o, dev_rx_valid_o, dev_tx_ready_o});
    end
    n_vec++; if (dev_rx_data_o !== 64'h0) begin n_err++; $display("FAIL reset_rx_data: got %h want 0", dev_rx_data_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (dev_tx_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_tx_ready: got %b want 1", dev_tx_ready_o); end
  endtask

  task automatic test_write_spec();
    logic [7:0] bytes [8] = '{8'h42, 8'h42, 8'h37, 8'h13, 8'hcd, 8'hab, 8'h34, 8'h12};
    int lat;
    for (int i = 0; i < 8; i++) begin
      host_write(bytes[i], 10, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL write_latency byte %0d: got %0d want 3", i, lat); end
    end
    n_vec++; if (dev_rx_valid_o !== 1'b1) begin n_err++; $display("FAIL write_rx_valid: got %b want 1", dev_rx_valid_o); end
    n_vec++; if (dev_rx_data_o !== 64'h1234_abcd_1337_4242) begin
      n_err++; $display("FAIL write_rx_data: got %h want 1234abcd13374242", dev_rx_data_o);
    end
    core_pop();
    n_vec++; if (dev_rx_valid_o !== 1'b0) begin n_err++; $display("FAIL write_rx_drained: got %b want 0", dev_rx_valid_o); end
  endtask

  task automatic test_read_spec();
    logic [63:0] w = 64'h0123_4567_89ab_cdef;
    logic [7:0] want [8] = '{8'hef, 8'hcd, 8'hab, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    logic [7:0] b;
    int lat;
    core_push(w);
    n_vec++; if (h_tx_avail_o !== 1'b1) begin n_err++; $display("FAIL read_tx_avail: got %b want 1", h_tx_avail_o); end
    for (int i = 0; i < 8; i++) begin
      host_read(10, lat, b);
      n_vec++; if (lat != 3 || b !== want[i]) begin
        n_err++; $display("FAIL read_byte %0d: got %h lat %0d want %h lat 3", i, b, lat, want[i]);
      end
      if (i == 6) begin
        n_vec++; if (h_tx_avail_o !== 1'b1) begin n_err++; $display("FAIL read_avail_mid: got %b want 1", h_tx_avail_o); end
      end
    end
    n_vec++; if (h_tx_avail_o !== 1'b0) begin n_err++; $display("FAIL read_avail_end: got %b want 0", h_tx_avail_o); end
  endtask

  task automatic test_rx_full();
    logic [63:0] q [$];
    logic [63:0] w;
    int bad, lat;
    for (int k = 0; k < 4; k++) begin
      w = rand_word();
      write_word(w, bad);
      q.push_back(w);
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL full_word_acks %0d: got %0d bad want 0", k, bad); end
      n_vec++; if (h_rx_full_o !== (k == 3)) begin n_err++; $display("FAIL full_flag word %0d: got %b want %b", k, h_rx_full_o, (k == 3)); end
    end
    w = rand_word();
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      host_write(byte_of(w, i), 10, lat);
      if (lat != 3) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL full_nonfinal_acks: got %0d bad want 0", bad); end
    host_write(byte_of(w, 7), 12, lat);
    n_vec++; if (lat != -1) begin n_err++; $display("FAIL full_stall: got ack after %0d want none", lat); end
    n_vec++; if (dev_rx_data_o !== q[0]) begin n_err++; $display("FAIL full_head_oldest: got %h want %h", dev_rx_data_o, q[0]); end
    core_pop();
    void'(q.pop_front());
    q.push_back(w);
    wait_wr_ack(4, lat);
    n_vec++; if (lat < 0) begin n_err++; $display("FAIL full_unstall: got no ack want ack"); end
    n_vec++; if (h_rx_full_o !== 1'b1) begin n_err++; $display("FAIL full_refill: got %b want 1", h_rx_full_o); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (dev_rx_valid_o !== 1'b1 || dev_rx_data_o !== q[k]) begin
        n_err++; $display("FAIL full_drain %0d: got v%b %h want v1 %h", k, dev_rx_valid_o, dev_rx_data_o, q[k]);
      end
      core_pop();
    end
    n_vec++; if (dev_rx_valid_o !== 1'b0) begin n_err++; $display("FAIL full_empty: got %b want 0", dev_rx_valid_o); end
  endtask

  task automatic test_read_stall();
    logic [63:0] w = rand_word();
    logic [7:0] b;
    int lat, bad;
    h_rd_tog_i = ~h_rd_tog_i;
    wait_rd_ack(10, lat);
    n_vec++; if (lat != -1) begin n_err++; $display("FAIL stall_no_ack: got ack after %0d want none", lat); end
    core_push(w);
    wait_rd_ack(2, lat);
    n_vec++; if (lat < 0 || h_data_o !== byte_of(w, 0)) begin
      n_err++; $display("FAIL stall_release: got %h lat %0d want %h", h_data_o, lat, byte_of(w, 0));
    end
    bad = 0;
    for (int i = 1; i < 8; i++) begin
      host_read(10, lat, b);
      if (lat != 3 || b !== byte_of(w, i)) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL stall_rest: got %0d bad bytes want 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a = rand_word();
    logic [63:0] b = rand_word();
    logic [63:0] got = 64'h0;
    int lw, lr, bad;
    core_push(a);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      h_data_i   = byte_of(b, i);
      h_wr_tog_i = ~h_wr_tog_i;
      h_rd_tog_i = ~h_rd_tog_i;
      lw = -1; lr = -1;
      for (int c = 1; c <= 10 && (lw < 0 || lr < 0); c++) begin
        @(posedge clk); #1;
        if (lw < 0 && h_wr_ack_o == h_wr_tog_i) lw = c;
        if (lr < 0 && h_rd_ack_o == h_rd_tog_i) begin lr = c; got = got | (64'(h_data_o) << (8 * i)); end
      end
      if (lw != 3 || lr != 3) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL b2b_latency: got %0d bad beats want 0", bad); end
    n_vec++; if (got !== a) begin n_err++; $display("FAIL b2b_read: got %h want %h", got, a); end
    n_vec++; if (dev_rx_data_o !== b || dev_rx_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_write: got %h want %h", dev_rx_data_o, b); end
    core_pop();
  endtask

  task automatic test_random();
    logic [63:0] q [$];
    logic [63:0] w;
    int bad, n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin w = rand_word(); q.push_back(w); core_push(w); end
      for (int k = 0; k < n; k++) begin
        read_word(w, bad);
        n_vec++; if (bad != 0 || w !== q[0]) begin n_err++; $display("FAIL rand_tx it%0d: got %h want %h bad %0d", it, w, q[0], bad); end
        void'(q.pop_front());
      end
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin w = rand_word(); q.push_back(w); write_word(w, bad); end
      for (int k = 0; k < n; k++) begin
        n_vec++; if (dev_rx_valid_o !== 1'b1 || dev_rx_data_o !== q[0]) begin
          n_err++; $display("FAIL rand_rx it%0d: got %h want %h", it, dev_rx_data_o, q[0]);
        end
        void'(q.pop_front());
        core_pop();
      end
    end
  endtask

  task automatic test_loopback();
    logic [31:0] w = 32'hdead_beef;
    logic [7:0] want [4] = '{8'hef, 8'hbe, 8'had, 8'hde};
    int ok;
    for (int i = 0; i < 4; i++) begin
      lb_h_data_i = w[8*i +: 8];
      lb_wr_tog   = ~lb_wr_tog;
      ok = 0;
      for (int c = 0; c < 10 && ok == 0; c++) begin @(posedge clk); #1; if (lb_wr_ack == lb_wr_tog) ok = 1; end
      n_vec++; if (ok == 0) begin n_err++; $display("FAIL lb_write_ack %0d: got none want ack", i); end
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({lb_rx_valid, lb_tx_ready, lb_tx_avail} !== 3'b001) begin
      n_err++; $display("FAIL lb_flags: got %b want 001", {lb_rx_valid, lb_tx_ready, lb_tx_avail});
    end
    for (int i = 0; i < 4; i++) begin
      lb_rd_tog = ~lb_rd_tog;
      ok = 0;
      for (int c = 0; c < 10 && ok == 0; c++) begin @(posedge clk); #1; if (lb_rd_ack == lb_rd_tog) ok = 1; end
      n_vec++; if (ok == 0 || lb_h_data_o !== want[i]) begin
        n_err++; $display("FAIL lb_read %0d: got %h ack %0d want %h", i, lb_h_data_o, ok, want[i]);
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [63:0] old_w = rand_word();
    logic [63:0] w = rand_word();
    int lat, bad;
    for (int i = 0; i < 3; i++) host_write(byte_of(old_w, i), 10, lat);
    rst_n = 1'b0;
    h_wr_tog_i = 1'b0; h_rd_tog_i = 1'b0; lb_wr_tog = 1'b0; lb_rd_tog = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (h_wr_ack_o !== 1'b0 || dev_rx_valid_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_state: got ack %b valid %b want 0 0", h_wr_ack_o, dev_rx_valid_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    host_write(byte_of(w, 0), 10, lat);
    n_vec++; if (lat != 3 || h_wr_ack_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_first_ack: got %b lat %0d want 1 lat 3", h_wr_ack_o, lat); end
    bad = 0;
    for (int i = 1; i < 8; i++) begin host_write(byte_of(w, i), 10, lat); if (lat != 3) bad++; end
    n_vec++; if (bad != 0 || dev_rx_data_o !== w) begin n_err++; $display("FAIL rst_mid_word: got %h want %h bad %0d", dev_rx_data_o, w, bad); end
    core_pop();
    n_vec++; if (dev_rx_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_only_one: got %b want 0", dev_rx_valid_o); end
  endtask

  initial begin
    test_reset();
    test_write_spec();
    test_read_spec();
    test_rx_full();
    test_read_stall();
    test_back_to_back();
    test_random();
    test_loopback();
    test_reset_midword();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
